// File: rtl/n64_joybus_responder_pkg.sv
// Shared joybus constants for the responder and the sniffer: timing in microseconds,
// command codes, device identity and responder FSM encodings.
package n64_joybus_responder_pkg;

    // Timing, in microseconds; modules scale by their clocks-per-microsecond parameter.
    localparam int unsigned JB_IDLE_US         = 8;
    localparam int unsigned JB_SAMPLE_US       = 2;
    localparam int unsigned JB_LOW_TIMEOUT_US  = 16;
    localparam int unsigned JB_EDGE_TIMEOUT_US = 8;
    localparam int unsigned JB_GAP_US          = 3;
    localparam int unsigned JB_CELL_US         = 4;
    localparam int unsigned JB_BIT0_LOW_US     = 3;
    localparam int unsigned JB_BIT1_LOW_US     = 1;
    localparam int unsigned JB_STOP_LOW_US     = 2;

    localparam logic [7:0]  JB_CMD_INFO  = 8'h00;
    localparam logic [7:0]  JB_CMD_POLL  = 8'h01;
    localparam logic [7:0]  JB_CMD_RESET = 8'hFF;
    localparam logic [23:0] JB_DEV_ID    = 24'h050002;

    localparam int unsigned JB_POLL_BITS = 32;
    localparam int unsigned JB_ID_BITS   = 24;

    // Sniffer-side framing limits.
    localparam int unsigned JB_SNIFF_CMD_BITS      = 8;
    localparam int unsigned JB_SNIFF_MAX_RESP_BITS = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX_CMD  = 3'd1;
    localparam logic [2:0] ST_RX_STOP = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_TX      = 3'd4;
    localparam logic [2:0] ST_TX_STOP = 3'd5;

    // The transmitter shifts LSB first; MSB-first fields are reversed once up front.
    function automatic logic [23:0] bitrev24(input logic [23:0] v);
        logic [23:0] r;
        for (int i = 0; i < 24; i++) begin
            r[i] = v[23 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/joybus_bit_tx.sv
// Generates one joybus bit cell (or the stop cell) as a registered open-drain enable;
// done marks the last cycle of the cell so a new start can follow back to back.
module joybus_bit_tx
    import n64_joybus_responder_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tx_bit,
    input  logic stop_mode,
    input  logic abort,
    output logic oe,
    output logic done
);

    localparam int unsigned CELL = JB_CELL_US * CLK_PER_US;
    localparam int unsigned CW   = $clog2(CELL);

    localparam logic [CW-1:0] LAST      = CW'(CELL - 1);
    localparam logic [CW-1:0] BIT0_LOW  = CW'(JB_BIT0_LOW_US * CLK_PER_US);
    localparam logic [CW-1:0] BIT1_LOW  = CW'(JB_BIT1_LOW_US * CLK_PER_US);
    localparam logic [CW-1:0] STOP_LOW  = CW'(JB_STOP_LOW_US * CLK_PER_US);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] low_len_q;
    logic [CW-1:0] low_len;
    logic          active_q;
    logic          oe_q;

    always_comb begin
        low_len = BIT0_LOW;
        if (stop_mode) begin
            low_len = STOP_LOW;
        end else if (tx_bit) begin
            low_len = BIT1_LOW;
        end
    end

    assign done = active_q && (cnt_q == LAST);
    assign oe   = oe_q;

    // Every cell starts pulled low; oe for cell cycle c is (c < low_len).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            low_len_q <= '0;
            active_q  <= 1'b0;
            oe_q      <= 1'b0;
        end else if (abort) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            oe_q     <= 1'b0;
        end else if (start) begin
            cnt_q     <= '0;
            low_len_q <= low_len;
            active_q  <= 1'b1;
            oe_q      <= 1'b1;
        end else if (done) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            oe_q     <= 1'b0;
        end else if (active_q) begin
            cnt_q <= cnt_q + CW'(1);
            oe_q  <= (cnt_q + CW'(1)) < low_len_q;
        end
    end

endmodule

// File: rtl/n64_joybus_responder.sv
// N64 controller-side joybus responder: receives a console command byte and answers
// poll (0x01) with the 32-bit payload and info/reset (0x00/0xFF) with the device ID.
module n64_joybus_responder
    import n64_joybus_responder_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 4
) (
    input  logic        CTRL_CLK,
    input  logic        CTRL_RST,
    input  logic        CTRL_i,
    output logic        CTRL_oe_o,
    input  logic        en_i,
    input  logic [31:0] ctrl_data_i,
    output logic        data_req_o,
    output logic        busy_o,
    output logic [7:0]  cmd_o
);

    localparam int unsigned TW = $clog2(JB_LOW_TIMEOUT_US * CLK_PER_US + 2);

    localparam logic [TW-1:0] IDLE_CYC    = TW'(JB_IDLE_US * CLK_PER_US);
    localparam logic [TW-1:0] SAMPLE_CYC  = TW'(JB_SAMPLE_US * CLK_PER_US);
    localparam logic [TW-1:0] LOW_TO_CYC  = TW'(JB_LOW_TIMEOUT_US * CLK_PER_US);
    localparam logic [TW-1:0] EDGE_TO_CYC = TW'(JB_EDGE_TIMEOUT_US * CLK_PER_US);
    localparam logic [TW-1:0] GAP_LAST    = TW'(JB_GAP_US * CLK_PER_US - 1);
    localparam logic [5:0]    POLL_LEN    = 6'(JB_POLL_BITS);
    localparam logic [5:0]    ID_LEN      = 6'(JB_ID_BITS);

    logic [2:0]    state_q, state_d;
    logic          line_q;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] low_cnt_q, low_cnt_d;
    logic [TW-1:0] gap_cnt_q, gap_cnt_d;
    logic          edge_seen_q, edge_seen_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    cmd_sr_q, cmd_sr_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          data_req_q, data_req_d;
    logic          busy_q, busy_d;
    logic [31:0]   tx_word_q, tx_word_d;
    logic [5:0]    tx_idx_q, tx_idx_d;
    logic [5:0]    tx_len_q, tx_len_d;

    logic          fall;
    logic          rx_active;
    logic          sample;
    logic [31:0]   tx_src;
    logic          tx_start;
    logic          tx_bit;
    logic          tx_stop;
    logic          tx_abort;
    logic          tx_oe;
    logic          tx_done;

    assign fall      = line_q & ~CTRL_i;
    assign rx_active = (state_q == ST_RX_CMD) || (state_q == ST_RX_STOP);
    assign sample    = edge_seen_q && (timer_q == SAMPLE_CYC);
    assign tx_src    = (cmd_q == JB_CMD_POLL) ? ctrl_data_i : {8'h00, bitrev24(JB_DEV_ID)};

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        timer_d     = timer_q;
        low_cnt_d   = low_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        edge_seen_d = edge_seen_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        cmd_d       = cmd_q;
        data_req_d  = 1'b0;
        tx_word_d   = tx_word_q;
        tx_idx_d    = tx_idx_q;
        tx_len_d    = tx_len_q;
        tx_start    = 1'b0;
        tx_bit      = 1'b0;
        tx_stop     = 1'b0;
        tx_abort    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!CTRL_i) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q < IDLE_CYC) begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
                if (fall && (idle_cnt_q >= IDLE_CYC)) begin
                    state_d     = ST_RX_CMD;
                    idle_cnt_d  = '0;
                    timer_d     = TW'(1);
                    low_cnt_d   = TW'(1);
                    edge_seen_d = 1'b1;
                    bit_cnt_d   = '0;
                    cmd_sr_d    = '0;
                end
            end
            ST_RX_CMD: begin
                if (sample) begin
                    edge_seen_d = 1'b0;
                    cmd_sr_d    = {cmd_sr_q[6:0], CTRL_i};
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_RX_STOP;
                    end
                end
            end
            ST_RX_STOP: begin
                if (sample) begin
                    edge_seen_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (CTRL_i) begin
                        case (cmd_sr_q)
                            JB_CMD_POLL: begin
                                cmd_d      = cmd_sr_q;
                                data_req_d = 1'b1;
                                gap_cnt_d  = '0;
                                state_d    = ST_GAP;
                            end
                            JB_CMD_INFO, JB_CMD_RESET: begin
                                cmd_d     = cmd_sr_q;
                                gap_cnt_d = '0;
                                state_d   = ST_GAP;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + TW'(1);
                // First cell is launched on the last gap cycle so the line drops right at 3U.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_TX;
                    tx_word_d = tx_src;
                    tx_len_d  = (cmd_q == JB_CMD_POLL) ? POLL_LEN : ID_LEN;
                    tx_idx_d  = 6'd1;
                    tx_start  = 1'b1;
                    tx_bit    = tx_src[0];
                end
            end
            ST_TX: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    if (tx_idx_q < tx_len_q) begin
                        tx_bit   = tx_word_q[tx_idx_q[4:0]];
                        tx_idx_d = tx_idx_q + 6'd1;
                    end else begin
                        tx_stop = 1'b1;
                        state_d = ST_TX_STOP;
                    end
                end
            end
            ST_TX_STOP: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared receive timing: restart the bit timer on each edge and abandon stalled frames.
        if (rx_active) begin
            timer_d   = timer_q + TW'(1);
            low_cnt_d = CTRL_i ? '0 : low_cnt_q + TW'(1);
            if (fall) begin
                timer_d     = TW'(1);
                edge_seen_d = 1'b1;
            end
            if ((low_cnt_q > LOW_TO_CYC) || (timer_q > EDGE_TO_CYC)) begin
                state_d = ST_IDLE;
            end
        end

        if (!en_i && ((state_q == ST_GAP) || (state_q == ST_TX) || (state_q == ST_TX_STOP))) begin
            state_d  = ST_IDLE;
            tx_start = 1'b0;
            tx_abort = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
        if (CTRL_RST) begin
            state_q     <= ST_IDLE;
            line_q      <= 1'b0;
            idle_cnt_q  <= '0;
            timer_q     <= '0;
            low_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            edge_seen_q <= 1'b0;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            cmd_q       <= '0;
            data_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            tx_word_q   <= '0;
            tx_idx_q    <= '0;
            tx_len_q    <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= CTRL_i;
            idle_cnt_q  <= idle_cnt_d;
            timer_q     <= timer_d;
            low_cnt_q   <= low_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            edge_seen_q <= edge_seen_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            cmd_q       <= cmd_d;
            data_req_q  <= data_req_d;
            busy_q      <= busy_d;
            tx_word_q   <= tx_word_d;
            tx_idx_q    <= tx_idx_d;
            tx_len_q    <= tx_len_d;
        end
    end

    joybus_bit_tx #(
        .CLK_PER_US(CLK_PER_US)
    ) u_bit_tx (
        .clk       (CTRL_CLK),
        .rst       (CTRL_RST),
        .start     (tx_start),
        .tx_bit    (tx_bit),
        .stop_mode (tx_stop),
        .abort     (tx_abort),
        .oe        (tx_oe),
        .done      (tx_done)
    );

    // Enable gates the registered drive directly so dropping it releases the line at once.
    assign CTRL_oe_o  = tx_oe & en_i;
    assign data_req_o = data_req_q;
    assign busy_o     = busy_q;
    assign cmd_o      = cmd_q;

endmodule

// File: tb/tb_n64_joybus_responder.sv
// Directed bench: a console model drives the wired-AND line and decodes the response cells.
module tb_n64_joybus_responder;

    logic        clk;
    logic        rst;
    logic        con_low;
    logic        en;
    logic        oe;
    logic        data_req;
    logic        busy;
    logic [31:0] data;
    logic [7:0]  cmd;
    logic        line;

    int n_cmp;
    int n_bad;
    int cyc;
    int dreq_n;
    int dreq_cyc;

    assign line = ~(con_low | oe);

    n64_joybus_responder #(
        .CLK_PER_US(4)
    ) dut (
        .CTRL_CLK    (clk),
        .CTRL_RST    (rst),
        .CTRL_i      (line),
        .CTRL_oe_o   (oe),
        .en_i        (en),
        .ctrl_data_i (data),
        .data_req_o  (data_req),
        .busy_o      (busy),
        .cmd_o       (cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (data_req === 1'b1) begin
            dreq_n++;
            dreq_cyc = cyc;
        end
    endtask

    task automatic send_bit(input logic b);
        con_low = 1'b1;
        repeat (b ? 4 : 12) tick();
        con_low = 1'b0;
        repeat (b ? 12 : 4) tick();
    endtask

    task automatic send_frame(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
        con_low = 1'b1;
        repeat (4) tick();
        con_low = 1'b0;
        repeat (4) tick();
    endtask

    task automatic watch(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            tick();
            if (oe === 1'b1) hi++;
        end
    endtask

    task automatic wait_rise(output logic found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (oe === 1'b1) found = 1'b1;
        end
    endtask

    // Cell value from its low time: 4 cycles low = 1, 12 cycles low = 0.
    task automatic get_resp(input int nbits, output logic [31:0] lsbw, output logic [31:0] msbw,
                            output int bad_cells, output int stop_hi, output logic busy_last,
                            output logic busy_after, output logic found, output int gap);
        logic first;
        int   hi;
        logic b;
        lsbw = '0;
        msbw = '0;
        bad_cells = 0;
        stop_hi = 0;
        busy_last = 1'b0;
        busy_after = 1'b1;
        wait_rise(found);
        gap = cyc - dreq_cyc;
        if (found) begin
            first = 1'b1;
            for (int k = 0; k <= nbits; k++) begin
                hi = 0;
                for (int c = 0; c < 16; c++) begin
                    if (!first) tick();
                    first = 1'b0;
                    if (oe === 1'b1) hi++;
                    if (c == 15) busy_last = busy;
                end
                if (k < nbits) begin
                    b = (hi == 4);
                    if (hi != 4 && hi != 12) bad_cells++;
                    lsbw[k] = b;
                    msbw = {msbw[30:0], b};
                end else begin
                    stop_hi = hi;
                end
            end
            tick();
            busy_after = busy;
        end
    endtask

    logic [31:0] lw;
    logic [31:0] mw;
    int          bad;
    int          shi;
    logic        bl;
    logic        ba;
    logic        found;
    int          gap;
    int          d0;
    int          hi;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        dreq_n = 0;
        dreq_cyc = 0;
        rst = 1'b0;
        con_low = 1'b0;
        en = 1'b1;
        data = 32'h12345678;
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_data_req", 32'(data_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd", 32'(cmd), 32'h00);
        rst = 1'b0;
        repeat (40) tick();

        // Poll: 32 LSB-first cells after a 12-cycle gap, then the stop cell.
        d0 = dreq_n;
        send_frame(8'h01);
        get_resp(32, lw, mw, bad, shi, bl, ba, found, gap);
        check("poll_found", 32'(found), 32'd1);
        check("poll_data_req_count", 32'(dreq_n - d0), 32'd1);
        check("poll_gap", 32'(gap), 32'd12);
        check("poll_payload", lw, 32'h12345678);
        check("poll_bad_cells", 32'(bad), 32'd0);
        check("poll_stop_low", 32'(shi), 32'd8);
        check("poll_busy_last", 32'(bl), 32'd1);
        check("poll_busy_after", 32'(ba), 32'd0);
        check("poll_cmd", 32'(cmd), 32'h01);
        repeat (40) tick();

        // Info: 24 MSB-first cells carrying the device ID.
        d0 = dreq_n;
        send_frame(8'h00);
        get_resp(24, lw, mw, bad, shi, bl, ba, found, gap);
        check("info_found", 32'(found), 32'd1);
        check("info_id", mw, 32'h00050002);
        check("info_bad_cells", 32'(bad), 32'd0);
        check("info_stop_low", 32'(shi), 32'd8);
        check("info_cmd", 32'(cmd), 32'h00);
        check("info_no_data_req", 32'(dreq_n - d0), 32'd0);
        repeat (40) tick();

        send_frame(8'hFF);
        get_resp(24, lw, mw, bad, shi, bl, ba, found, gap);
        check("reset_cmd_id", mw, 32'h00050002);
        check("reset_cmd_cmd", 32'(cmd), 32'hFF);
        repeat (40) tick();

        // Unsupported command: silent, cmd_o unchanged.
        send_frame(8'h02);
        watch(60, hi);
        check("cmd02_no_drive", 32'(hi), 32'd0);
        check("cmd02_cmd_kept", 32'(cmd), 32'hFF);
        check("cmd02_busy", 32'(busy), 32'd0);
        repeat (40) tick();

        // Line stuck low after the third command bit, then a clean poll.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("to_busy_in_frame", 32'(busy), 32'd1);
        con_low = 1'b1;
        watch(80, hi);
        check("to_busy_cleared", 32'(busy), 32'd0);
        check("to_no_drive", 32'(hi), 32'd0);
        con_low = 1'b0;
        repeat (40) tick();
        data = 32'hA5C30F81;
        send_frame(8'h01);
        get_resp(32, lw, mw, bad, shi, bl, ba, found, gap);
        check("to_recover_payload", lw, 32'hA5C30F81);
        check("to_recover_bad_cells", 32'(bad), 32'd0);
        repeat (40) tick();

        // Enable dropped in the 10th response cell.
        data = 32'h12345678;
        send_frame(8'h01);
        wait_rise(found);
        check("en_found", 32'(found), 32'd1);
        repeat (146) tick();
        check("en_pre_drop_oe", 32'(oe), 32'd1);
        en = 1'b0;
        #1;
        check("en_drop_oe", 32'(oe), 32'd0);
        watch(60, hi);
        check("en_no_further_drive", 32'(hi), 32'd0);
        check("en_busy", 32'(busy), 32'd0);
        en = 1'b1;
        repeat (40) tick();

        // Reset mid-response, then re-qualification of the idle line.
        send_frame(8'h01);
        wait_rise(found);
        repeat (20) tick();
        check("rst_mid_pre_oe", 32'(oe), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_oe", 32'(oe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_cmd", 32'(cmd), 32'h00);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        d0 = dreq_n;
        send_frame(8'h01);
        watch(80, hi);
        check("early_no_drive", 32'(hi), 32'd0);
        check("early_no_data_req", 32'(dreq_n - d0), 32'd0);
        check("early_cmd", 32'(cmd), 32'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (40) tick();
        d0 = dreq_n;
        send_frame(8'h01);
        get_resp(32, lw, mw, bad, shi, bl, ba, found, gap);
        check("late_payload", lw, 32'h12345678);
        check("late_data_req", 32'(dreq_n - d0), 32'd1);
        check("late_cmd", 32'(cmd), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
